// File: rtl/wishbone_master_if.sv
// ---------------------------------------------------------------------------
// wishbone_master_if
//
// Purpose:
//   Groups the core-side request/response handshake and the Wishbone classic
//   bus signals of the wishbone_master block into a single bundle.
//
// Signal summary:
//   Core request  : req_valid, req_ready, req_we, req_size[1:0], req_signed,
//                   req_addr[31:0], req_wdata[31:0]
//   Core response : resp_valid, resp_rdata[31:0], resp_err
//   Wishbone out  : CYC_O, STB_O, WE_O, ADR_O[31:0], SEL_O[3:0], DAT_O[31:0]
//   Wishbone in   : DAT_I[31:0], ACK_I, ERR_I
//
// Modports:
//   master : the view of the wishbone_master block itself
//   slave  : the view of everything around it (core plus Wishbone slave)
// ---------------------------------------------------------------------------
interface wishbone_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [31:0] ADR_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;
    logic        ERR_I;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  DAT_I, ACK_I, ERR_I,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output CYC_O, STB_O, WE_O, ADR_O, SEL_O, DAT_O
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output DAT_I, ACK_I, ERR_I,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  CYC_O, STB_O, WE_O, ADR_O, SEL_O, DAT_O
    );

endinterface

// File: rtl/wishbone_master.sv
// ---------------------------------------------------------------------------
// wishbone_master
//
// Purpose:
//   Turns single byte/half/word load-store requests from a core into
//   Wishbone classic bus cycles. Misaligned or reserved-size requests are
//   answered with an error without touching the bus. Load data is pulled
//   from the addressed byte lane and zero- or sign-extended. A bus cycle
//   that sees neither ACK_I nor ERR_I within TIMEOUT cycles is aborted with
//   an error.
//
// Parameters:
//   TIMEOUT : WAIT cycles without termination before abort (1..255)
//
// Ports:
//   CLK_I : clock, everything on the rising edge
//   RST_I : synchronous active-high reset
//   bus   : wishbone_master_if.master, carrying
//           req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata,
//           resp_valid/resp_rdata/resp_err,
//           CYC_O/STB_O/WE_O/ADR_O/SEL_O/DAT_O and DAT_I/ACK_I/ERR_I
// ---------------------------------------------------------------------------
module wishbone_master #(
    parameter int TIMEOUT = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    wishbone_master_if.master bus
);

    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  count_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] datO_q;
    logic        respValid_q;
    logic [31:0] respRdata_q;
    logic        respErr_q;
    logic        reqReady_q;

    logic        misaligned_d;
    logic [3:0]  sel_d;
    logic [31:0] datO_d;
    logic [7:0]  loadByte_d;
    logic [15:0] loadHalf_d;
    logic [31:0] loadData_d;

    // Decode the incoming request: alignment check, byte-lane enables and
    // the write data copied onto every lane it could land on, so the slave
    // picks the right bytes purely from SEL_O.
    always_comb begin
        misaligned_d = 1'b0;
        sel_d        = 4'b0000;
        datO_d       = 32'h0000_0000;
        case (bus.req_size)
            2'b00: begin
                sel_d  = 4'b0001 << bus.req_addr[1:0];
                datO_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned_d = bus.req_addr[0];
                sel_d        = 4'b0011 << bus.req_addr[1:0];
                datO_d       = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned_d = |bus.req_addr[1:0];
                sel_d        = 4'b1111;
                datO_d       = bus.req_wdata;
            end
            default: begin
                misaligned_d = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane out of DAT_I and extend it to 32 bits. A half
    // is always aligned by the time it reaches the bus, so only the upper
    // lane bit matters for it.
    always_comb begin
        loadByte_d = 8'h00;
        case (lane_q)
            2'd0:    loadByte_d = bus.DAT_I[7:0];
            2'd1:    loadByte_d = bus.DAT_I[15:8];
            2'd2:    loadByte_d = bus.DAT_I[23:16];
            default: loadByte_d = bus.DAT_I[31:24];
        endcase
        loadHalf_d = lane_q[1] ? bus.DAT_I[31:16] : bus.DAT_I[15:0];
        loadData_d = 32'h0000_0000;
        case (size_q)
            2'b00:   loadData_d = {{24{signed_q & loadByte_d[7]}}, loadByte_d};
            2'b01:   loadData_d = {{16{signed_q & loadHalf_d[15]}}, loadHalf_d};
            2'b10:   loadData_d = bus.DAT_I;
            default: loadData_d = 32'h0000_0000;
        endcase
    end

    // Main controller. All outputs are registered here so the bus side sees
    // glitch-free, stable values for the whole WAIT phase. ERR_I is tested
    // before ACK_I so an error always wins, and a termination on the last
    // allowed cycle is honoured ahead of the timeout.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0000_0000;
            sel_q       <= 4'b0000;
            datO_q      <= 32'h0000_0000;
            respValid_q <= 1'b0;
            respRdata_q <= 32'h0000_0000;
            respErr_q   <= 1'b0;
            reqReady_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && reqReady_q) begin
                        reqReady_q <= 1'b0;
                        size_q     <= bus.req_size;
                        signed_q   <= bus.req_signed;
                        lane_q     <= bus.req_addr[1:0];
                        if (misaligned_d) begin
                            state_q     <= DONE;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            respRdata_q <= 32'h0000_0000;
                        end else begin
                            state_q <= WAIT;
                            count_q <= 8'd1;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= bus.req_we;
                            adr_q   <= {bus.req_addr[31:2], 2'b00};
                            sel_q   <= sel_d;
                            datO_q  <= datO_d;
                        end
                    end
                end
                WAIT: begin
                    if (bus.ERR_I) begin
                        state_q     <= DONE;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        respValid_q <= 1'b1;
                        respErr_q   <= 1'b1;
                        respRdata_q <= 32'h0000_0000;
                    end else if (bus.ACK_I) begin
                        state_q     <= DONE;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        respValid_q <= 1'b1;
                        respErr_q   <= 1'b0;
                        respRdata_q <= we_q ? 32'h0000_0000 : loadData_d;
                    end else if (count_q == TimeoutCount) begin
                        state_q     <= DONE;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        respValid_q <= 1'b1;
                        respErr_q   <= 1'b1;
                        respRdata_q <= 32'h0000_0000;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    count_q     <= 8'd0;
                    respValid_q <= 1'b0;
                    respErr_q   <= 1'b0;
                    respRdata_q <= 32'h0000_0000;
                    reqReady_q  <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = reqReady_q;
    assign bus.resp_valid = respValid_q;
    assign bus.resp_rdata = respRdata_q;
    assign bus.resp_err   = respErr_q;
    assign bus.CYC_O      = cyc_q;
    assign bus.STB_O      = stb_q;
    assign bus.WE_O       = we_q;
    assign bus.ADR_O      = adr_q;
    assign bus.SEL_O      = sel_q;
    assign bus.DAT_O      = datO_q;

endmodule

// File: tb/tb_wishbone_master.sv
// ---------------------------------------------------------------------------
// tb_wishbone_master
//
// Purpose:
//   Self-checking bench for wishbone_master. A byte-addressed memory model
//   predicts load results and bus lane usage; a word RAM behind a scripted
//   Wishbone slave answers the DUT's bus cycles with chosen wait states and
//   terminations.
// ---------------------------------------------------------------------------
module tb_wishbone_master;

    localparam int TB_TIMEOUT = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic CLK_I = 1'b0;
    logic RST_I;

    wishbone_master_if bus ();

    wishbone_master #(.TIMEOUT(TB_TIMEOUT)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    always #5 CLK_I = ~CLK_I;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0]  modelMem [0:255];
    logic [31:0] ram      [0:63];

    typedef struct {
        int          stbCycles;
        int          busCycles;
        int          respCycle;
        int          readyCycle;
        int          respCount;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        bit          stable;
        bit          timedOut;
    } obs_t;

    typedef struct {
        int          stb;
        int          resp;
        int          ready;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          commit;
    } exp_t;

    // Behavioural prediction of one request from the byte-level rules.
    function automatic exp_t predict(input logic we, input logic [1:0] size, input logic sgn,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int waitCycles, input int kind);
        exp_t   e;
        int     n;
        int     base;
        longint v;
        e = '{default: 0};
        n = 1 << size;
        base = int'(addr % 32'd4);
        if (size == 2'b11 || (addr % 32'(n)) != 0) begin
            e.stb = 0;
            e.resp = 1;
            e.err = 1'b1;
        end else begin
            e.adr = addr - (addr % 32'd4);
            for (int b = 0; b < n; b++) e.sel[base + b] = 1'b1;
            for (int l = 0; l < 4; l++) e.dat[8*l +: 8] = wdata[8*(l % n) +: 8];
            if (kind == K_NONE || waitCycles >= TB_TIMEOUT) begin
                e.stb = TB_TIMEOUT;
                e.err = 1'b1;
            end else begin
                e.stb = waitCycles + 1;
                e.err = (kind != K_ACK);
            end
            e.resp = e.stb + 1;
            if (!e.err && !we) begin
                v = 0;
                for (int b = 0; b < n; b++) v += longint'(modelMem[int'(addr[7:0]) + b]) << (8*b);
                if (sgn && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
                e.rdata = 32'(v);
            end
            e.commit = !e.err && we;
        end
        e.ready = e.resp + 1;
        return e;
    endfunction

    // Apply a successful store to the byte model.
    task automatic modelStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        for (int b = 0; b < (1 << size); b++) modelMem[int'(addr[7:0]) + b] = wdata[8*b +: 8];
    endtask

    // Drive one request and play the slave side, recording what the DUT did.
    // While the DUT is busy the request inputs are scrambled to show they are
    // ignored; the slave terminates on WAIT cycle waitCycles+1 with 'kind'.
    task automatic busTxn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int waitCycles, input int kind, output obs_t o);
        int c;
        o = '{default: 0};
        o.stable = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge CLK_I); #1;
        c = 1;
        while (1) begin
            bus.ACK_I      = 1'b0;
            bus.ERR_I      = 1'b0;
            bus.DAT_I      = $urandom;
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_we     = 1'($urandom_range(0, 1));
            bus.req_size   = 2'($urandom_range(0, 3));
            bus.req_signed = 1'($urandom_range(0, 1));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            if (bus.CYC_O || bus.STB_O) o.busCycles++;
            if (bus.CYC_O && bus.STB_O) begin
                o.stbCycles++;
                if (o.stbCycles == 1) begin
                    o.sel = bus.SEL_O;
                    o.adr = bus.ADR_O;
                    o.dat = bus.DAT_O;
                    o.we  = bus.WE_O;
                end else if (o.sel !== bus.SEL_O || o.adr !== bus.ADR_O ||
                             o.dat !== bus.DAT_O || o.we !== bus.WE_O) begin
                    o.stable = 1'b0;
                end
                if (kind != K_NONE && o.stbCycles == waitCycles + 1) begin
                    bus.DAT_I = ram[bus.ADR_O[7:2]];
                    if (kind == K_ACK) begin
                        bus.ACK_I = 1'b1;
                        if (bus.WE_O) begin
                            for (int l = 0; l < 4; l++)
                                if (bus.SEL_O[l]) ram[bus.ADR_O[7:2]][8*l +: 8] = bus.DAT_O[8*l +: 8];
                        end
                    end else if (kind == K_ERR) begin
                        bus.ERR_I = 1'b1;
                    end else begin
                        bus.ACK_I = 1'b1;
                        bus.ERR_I = 1'b1;
                    end
                end
            end
            if (bus.resp_valid) begin
                o.respCount++;
                if (o.respCount == 1) begin
                    o.respCycle = c;
                    o.rdata = bus.resp_rdata;
                    o.err   = bus.resp_err;
                end
            end
            if (o.respCount > 0 && bus.req_ready) begin
                o.readyCycle = c;
                break;
            end
            if (c >= 300) begin
                o.timedOut = 1'b1;
                break;
            end
            @(posedge CLK_I); #1;
            c++;
        end
        bus.req_valid = 1'b0;
        bus.ACK_I     = 1'b0;
        bus.ERR_I     = 1'b0;
    endtask

    // Reset values of every output, then readiness after release.
    task automatic test_reset();
        RST_I = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.DAT_I = 32'h0; bus.ACK_I = 1'b0; bus.ERR_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;
        assertCount++; if (bus.CYC_O !== 1'b0) begin failCount++; $display("[TB] FAIL reset_cyc: got %0b expected 0", bus.CYC_O); end
        assertCount++; if (bus.STB_O !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stb: got %0b expected 0", bus.STB_O); end
        assertCount++; if (bus.WE_O !== 1'b0) begin failCount++; $display("[TB] FAIL reset_we: got %0b expected 0", bus.WE_O); end
        assertCount++; if (bus.SEL_O !== 4'h0) begin failCount++; $display("[TB] FAIL reset_sel: got %h expected 0", bus.SEL_O); end
        assertCount++; if (bus.ADR_O !== 32'h0) begin failCount++; $display("[TB] FAIL reset_adr: got %h expected 0", bus.ADR_O); end
        assertCount++; if (bus.DAT_O !== 32'h0) begin failCount++; $display("[TB] FAIL reset_dat: got %h expected 0", bus.DAT_O); end
        assertCount++; if (bus.resp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_resp_valid: got %0b expected 0", bus.resp_valid); end
        assertCount++; if (bus.resp_rdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.resp_rdata); end
        assertCount++; if (bus.resp_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %0b expected 0", bus.resp_err); end
        RST_I = 1'b0;
        @(posedge CLK_I); #1;
        assertCount++; if (bus.req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.req_ready); end
    endtask

    // Word store with zero-wait ACK, including minimum latency.
    task automatic test_store_word();
        obs_t o;
        busTxn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, K_ACK, o);
        modelStore(2'b10, 32'h10, 32'hDEADBEEF);
        assertCount++; if (o.sel !== 4'b1111) begin failCount++; $display("[TB] FAIL sw_sel: got %b expected 1111", o.sel); end
        assertCount++; if (o.adr !== 32'h10) begin failCount++; $display("[TB] FAIL sw_adr: got %h expected 00000010", o.adr); end
        assertCount++; if (o.dat !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL sw_dat: got %h expected deadbeef", o.dat); end
        assertCount++; if (o.we !== 1'b1) begin failCount++; $display("[TB] FAIL sw_we: got %0b expected 1", o.we); end
        assertCount++; if (o.stbCycles !== 1) begin failCount++; $display("[TB] FAIL sw_stb_cycles: got %0d expected 1", o.stbCycles); end
        assertCount++; if (o.respCycle !== 2) begin failCount++; $display("[TB] FAIL sw_resp_cycle: got %0d expected 2", o.respCycle); end
        assertCount++; if (o.readyCycle !== 3) begin failCount++; $display("[TB] FAIL sw_ready_cycle: got %0d expected 3", o.readyCycle); end
        assertCount++; if (o.err !== 1'b0) begin failCount++; $display("[TB] FAIL sw_err: got %0b expected 0", o.err); end
        assertCount++; if (o.rdata !== 32'h0) begin failCount++; $display("[TB] FAIL sw_rdata: got %h expected 0", o.rdata); end
        assertCount++; if (ram[4] !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL sw_ram: got %h expected deadbeef", ram[4]); end
        assertCount++; if (o.timedOut !== 1'b0) begin failCount++; $display("[TB] FAIL sw_watchdog: got %0b expected 0", o.timedOut); end
    endtask

    // Byte loads from the top lane, signed and unsigned.
    task automatic test_byte_load();
        obs_t o;
        ram[4] = 32'h80112233;
        modelMem[16] = 8'h33; modelMem[17] = 8'h22; modelMem[18] = 8'h11; modelMem[19] = 8'h80;
        busTxn(1'b0, 2'b00, 1'b1, 32'h13, $urandom, 0, K_ACK, o);
        assertCount++; if (o.sel !== 4'b1000) begin failCount++; $display("[TB] FAIL lb_sel: got %b expected 1000", o.sel); end
        assertCount++; if (o.adr !== 32'h10) begin failCount++; $display("[TB] FAIL lb_adr: got %h expected 00000010", o.adr); end
        assertCount++; if (o.rdata !== 32'hFFFFFF80) begin failCount++; $display("[TB] FAIL lb_signed: got %h expected ffffff80", o.rdata); end
        assertCount++; if (o.err !== 1'b0) begin failCount++; $display("[TB] FAIL lb_err: got %0b expected 0", o.err); end
        busTxn(1'b0, 2'b00, 1'b0, 32'h13, $urandom, 0, K_ACK, o);
        assertCount++; if (o.rdata !== 32'h00000080) begin failCount++; $display("[TB] FAIL lbu_unsigned: got %h expected 00000080", o.rdata); end
        assertCount++; if (o.respCycle !== 2) begin failCount++; $display("[TB] FAIL lbu_resp_cycle: got %0d expected 2", o.respCycle); end
    endtask

    // Misaligned and reserved-size requests never reach the bus.
    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] addrs [3] = '{32'h05, 32'h02, 32'h10};
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            busTxn(1'b0, sizes[i], 1'b0, addrs[i], $urandom, 0, K_ACK, o);
            assertCount++; if (o.busCycles !== 0) begin failCount++; $display("[TB] FAIL mis_cyc[%0d]: got %0d bus cycles expected 0", i, o.busCycles); end
            assertCount++; if (o.respCycle !== 1) begin failCount++; $display("[TB] FAIL mis_resp_cycle[%0d]: got %0d expected 1", i, o.respCycle); end
            assertCount++; if (o.err !== 1'b1) begin failCount++; $display("[TB] FAIL mis_err[%0d]: got %0b expected 1", i, o.err); end
            assertCount++; if (o.rdata !== 32'h0) begin failCount++; $display("[TB] FAIL mis_rdata[%0d]: got %h expected 0", i, o.rdata); end
            assertCount++; if (o.readyCycle !== 2) begin failCount++; $display("[TB] FAIL mis_ready_cycle[%0d]: got %0d expected 2", i, o.readyCycle); end
        end
    endtask

    // Silent slave aborts after TIMEOUT cycles; ACK on the last cycle still counts.
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        busTxn(1'b0, 2'b10, 1'b0, 32'h20, $urandom, 0, K_NONE, o);
        assertCount++; if (o.stbCycles !== 4) begin failCount++; $display("[TB] FAIL to_stb_cycles: got %0d expected 4", o.stbCycles); end
        assertCount++; if (o.busCycles !== 4) begin failCount++; $display("[TB] FAIL to_cyc_cycles: got %0d expected 4", o.busCycles); end
        assertCount++; if (o.err !== 1'b1) begin failCount++; $display("[TB] FAIL to_err: got %0b expected 1", o.err); end
        assertCount++; if (o.respCycle !== 5) begin failCount++; $display("[TB] FAIL to_resp_cycle: got %0d expected 5", o.respCycle); end
        assertCount++; if (o.stable !== 1'b1) begin failCount++; $display("[TB] FAIL to_stable: got %0b expected 1", o.stable); end
        e = predict(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 3, K_ACK);
        busTxn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 3, K_ACK, o);
        assertCount++; if (o.err !== 1'b0) begin failCount++; $display("[TB] FAIL to_last_ack_err: got %0b expected 0", o.err); end
        assertCount++; if (o.rdata !== e.rdata) begin failCount++; $display("[TB] FAIL to_last_ack_rdata: got %h expected %h", o.rdata, e.rdata); end
        busTxn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 4, K_ACK, o);
        assertCount++; if (o.err !== 1'b1) begin failCount++; $display("[TB] FAIL to_late_ack_err: got %0b expected 1", o.err); end
        assertCount++; if (o.stbCycles !== 4) begin failCount++; $display("[TB] FAIL to_late_ack_stb: got %0d expected 4", o.stbCycles); end
    endtask

    // ERR_I beats ACK_I; stray terminations in IDLE do nothing.
    task automatic test_err_priority();
        obs_t o;
        exp_t e;
        int   badResp;
        busTxn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, K_BOTH, o);
        assertCount++; if (o.err !== 1'b1) begin failCount++; $display("[TB] FAIL both_err: got %0b expected 1", o.err); end
        assertCount++; if (o.rdata !== 32'h0) begin failCount++; $display("[TB] FAIL both_rdata: got %h expected 0", o.rdata); end
        assertCount++; if (o.respCycle !== 4) begin failCount++; $display("[TB] FAIL both_resp_cycle: got %0d expected 4", o.respCycle); end
        badResp = 0;
        bus.ACK_I = 1'b1;
        bus.ERR_I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DAT_I = $urandom;
            @(posedge CLK_I); #1;
            if (bus.resp_valid !== 1'b0 || bus.CYC_O !== 1'b0 || bus.req_ready !== 1'b1) badResp++;
        end
        bus.ACK_I = 1'b0;
        bus.ERR_I = 1'b0;
        assertCount++; if (badResp !== 0) begin failCount++; $display("[TB] FAIL stray_ack: got %0d disturbed cycles expected 0", badResp); end
        e = predict(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, K_ACK);
        busTxn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, K_ACK, o);
        assertCount++; if (o.rdata !== e.rdata || o.err !== 1'b0) begin failCount++; $display("[TB] FAIL after_stray: got %h/%0b expected %h/0", o.rdata, o.err, e.rdata); end
    endtask

    // Reset in the middle of a bus cycle drops it without a response.
    task automatic test_reset_midflight();
        int respSeen;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h0;
        @(posedge CLK_I); #1;
        bus.req_valid = 1'b0;
        @(posedge CLK_I); #1;
        assertCount++; if (bus.CYC_O !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_busy: got %0b expected 1", bus.CYC_O); end
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        assertCount++; if (bus.CYC_O !== 1'b0 || bus.STB_O !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_bus: got cyc %0b stb %0b expected 0 0", bus.CYC_O, bus.STB_O); end
        RST_I = 1'b0;
        respSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid !== 1'b0) respSeen++;
            @(posedge CLK_I); #1;
        end
        assertCount++; if (respSeen !== 0) begin failCount++; $display("[TB] FAIL rst_mid_resp: got %0d pulses expected 0", respSeen); end
        assertCount++; if (bus.req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_ready: got %0b expected 1", bus.req_ready); end
    endtask

    // Random back-to-back traffic against the byte-level model.
    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        int          waitCycles, kind, r;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = 32'($urandom_range(0, 255));
            if (size != 2'b11 && $urandom_range(0, 9) < 7) addr = addr & ~32'((1 << size) - 1);
            wdata = $urandom;
            waitCycles = $urandom_range(0, 5);
            r = $urandom_range(0, 9);
            kind = (r < 7) ? K_ACK : (r == 7) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
            e = predict(we, size, sgn, addr, wdata, waitCycles, kind);
            busTxn(we, size, sgn, addr, wdata, waitCycles, kind, o);
            if (e.commit) modelStore(size, addr, wdata);
            assertCount++; if (o.err !== e.err) begin failCount++; $display("[TB] FAIL rand_err[%0d]: got %0b expected %0b", i, o.err, e.err); end
            assertCount++; if (o.rdata !== e.rdata) begin failCount++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i, o.rdata, e.rdata); end
            assertCount++; if (o.busCycles !== e.stb || o.stbCycles !== e.stb) begin failCount++; $display("[TB] FAIL rand_bus_cycles[%0d]: got %0d/%0d expected %0d", i, o.busCycles, o.stbCycles, e.stb); end
            assertCount++; if (o.respCycle !== e.resp || o.readyCycle !== e.ready) begin failCount++; $display("[TB] FAIL rand_timing[%0d]: got resp %0d ready %0d expected %0d %0d", i, o.respCycle, o.readyCycle, e.resp, e.ready); end
            assertCount++; if (o.respCount !== 1 || o.timedOut !== 1'b0) begin failCount++; $display("[TB] FAIL rand_pulses[%0d]: got %0d pulses watchdog %0b expected 1 0", i, o.respCount, o.timedOut); end
            if (e.stb > 0) begin
                assertCount++; if (o.sel !== e.sel || o.adr !== e.adr) begin failCount++; $display("[TB] FAIL rand_sel_adr[%0d]: got %b %h expected %b %h", i, o.sel, o.adr, e.sel, e.adr); end
                assertCount++; if (o.we !== we || (we && o.dat !== e.dat)) begin failCount++; $display("[TB] FAIL rand_we_dat[%0d]: got %0b %h expected %0b %h", i, o.we, o.dat, we, e.dat); end
                assertCount++; if (o.stable !== 1'b1) begin failCount++; $display("[TB] FAIL rand_stable[%0d]: got %0b expected 1", i, o.stable); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) modelMem[i] = 8'($urandom);
        for (int w = 0; w < 64; w++)
            ram[w] = {modelMem[4*w+3], modelMem[4*w+2], modelMem[4*w+1], modelMem[4*w]};
        $display("[TB] wishbone_master bench start, TIMEOUT=%0d", TB_TIMEOUT);
        test_reset();
        test_store_word();
        test_byte_load();
        test_misaligned();
        test_timeout();
        test_err_priority();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
